// File: rtl/fixed_point_addsub_pipe.sv
// Signed fixed-point adder/subtractor with carry/borrow-in, optional
// saturation, an elastic valid/ready pipeline of STAGES registers and a
// saturating count of delivered overflow beats.
module fixed_point_addsub_pipe #(
   parameter int N        = 32,
   parameter int STAGES   = 2,
   parameter int SATURATE = 1,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [N-1:0] a,
   input  logic signed [N-1:0] b,
   input  logic                op,
   input  logic                carry_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [N-1:0] c,
   output logic                carry_out,
   output logic                overflow,
   output logic [CNT_W-1:0]    ovf_count,
   input  logic                ovf_clr
);

   // Clamp the N+1-bit result to N bits when the sign bits disagree
   // (SATURATE=1); otherwise simply drop the guard bit (wrap).
   function automatic logic signed [N-1:0] sat_result(input logic [N:0] r);
      logic signed [N-1:0] v;
      v = r[N-1:0];
      if ((SATURATE != 0) && (r[N] != r[N-1])) begin
         v = r[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      end
      return v;
   endfunction

   logic [N:0]          a_ext;
   logic [N:0]          b_ext;
   logic [N:0]          sum_s;
   logic [N:0]          sum_u;
   logic                cin_eff;
   logic signed [N-1:0] res_c;
   logic                res_cout;
   logic                res_ovf;

   logic [STAGES-1:0]   vld;
   logic signed [N-1:0] c_q [STAGES];
   logic [STAGES-1:0]   cout_q;
   logic [STAGES-1:0]   ovf_q;
   logic [STAGES-1:0]   load;

   // Arithmetic on sign-extended operands; subtract is a + ~b + !borrow.
   // The unsigned sum gives carry (add) or inverted borrow (subtract).
   always_comb begin
      cin_eff  = op ? ~carry_in : carry_in;
      a_ext    = {a[N-1], a};
      b_ext    = op ? ~{b[N-1], b} : {b[N-1], b};
      sum_s    = a_ext + b_ext + {{N{1'b0}}, cin_eff};
      sum_u    = {1'b0, a} + {1'b0, (op ? ~b : b)} + {{N{1'b0}}, cin_eff};
      res_ovf  = sum_s[N] ^ sum_s[N-1];
      res_cout = op ? ~sum_u[N] : sum_u[N];
      res_c    = sat_result(sum_s);
   end

   // Stall chain, walked from the output back to the input: a stage may
   // load when it is empty or its content leaves in the same cycle.
   always_comb begin : stall_chain
      logic nxt;
      load = '0;
      nxt  = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         load[k] = ~vld[k] | nxt;
         nxt     = load[k];
      end
   end

   assign in_ready  = rst_n & load[0];
   assign out_valid = vld[STAGES-1];
   assign c         = c_q[STAGES-1];
   assign carry_out = cout_q[STAGES-1];
   assign overflow  = ovf_q[STAGES-1];

   // Pipeline registers: stage 0 captures the finished result, later
   // stages shift forward whenever their successor makes room.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld    <= '0;
         cout_q <= '0;
         ovf_q  <= '0;
         for (int k = 0; k < STAGES; k++) begin
            c_q[k] <= '0;
         end
      end else begin
         // stage 0 boundary
         if (load[0]) begin
            vld[0] <= in_valid;
            if (in_valid) begin
               c_q[0]    <= res_c;
               cout_q[0] <= res_cout;
               ovf_q[0]  <= res_ovf;
            end
         end
         // stage k-1 -> k boundaries
         for (int k = 1; k < STAGES; k++) begin
            if (load[k]) begin
               vld[k] <= vld[k-1];
               if (vld[k-1]) begin
                  c_q[k]    <= c_q[k-1];
                  cout_q[k] <= cout_q[k-1];
                  ovf_q[k]  <= ovf_q[k-1];
               end
            end
         end
      end
   end

   // Saturating count of delivered overflow beats; a clear takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_count <= '0;
      end else if (ovf_clr) begin
         ovf_count <= '0;
      end else if (out_valid && out_ready && overflow && (ovf_count != {CNT_W{1'b1}})) begin
         ovf_count <= ovf_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_fixed_point_addsub_pipe.sv
// Bench for fixed_point_addsub_pipe: a saturating 3-stage 8-bit instance
// (counter width 4) and a wrapping 2-stage 8-bit instance share operands.
module tb_fixed_point_addsub_pipe;

   typedef struct packed {
      logic [7:0] c;
      logic       cout;
      logic       ovf;
   } exp_t;

   typedef struct {
      logic       op;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] c_sat;
      logic [7:0] c_wrap;
      logic       cout;
      logic       ovf;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  a, b;
   logic        op, cin;
   logic        in_valid_a, in_valid_b;
   logic        out_ready, ovf_clr;

   logic        in_ready_a, out_valid_a, carry_out_a, overflow_a;
   logic [7:0]  c_a;
   logic [3:0]  ovf_count_a;
   logic        in_ready_b, out_valid_b, carry_out_b, overflow_b;
   logic [7:0]  c_b;
   logic [15:0] ovf_count_b;

   exp_t q_a[$];
   exp_t q_b[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   del_a = 0, del_b = 0;
   int   m_cnt_a = 0, m_cnt_b = 0;
   exp_t e_a, e_b;
   logic dlv_a, dlv_b;
   vec_t vt[14];

   always #5 clk = ~clk;

   fixed_point_addsub_pipe #(.N(8), .STAGES(3), .SATURATE(1), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .a(a), .b(b), .op(op), .carry_in(cin), .out_valid(out_valid_a),
      .out_ready(out_ready), .c(c_a), .carry_out(carry_out_a), .overflow(overflow_a),
      .ovf_count(ovf_count_a), .ovf_clr(ovf_clr)
   );

   fixed_point_addsub_pipe #(.N(8), .STAGES(2), .SATURATE(0), .CNT_W(16)) u_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .a(a), .b(b), .op(op), .carry_in(cin), .out_valid(out_valid_b),
      .out_ready(out_ready), .c(c_b), .carry_out(carry_out_b), .overflow(overflow_b),
      .ovf_count(ovf_count_b), .ovf_clr(ovf_clr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   function automatic exp_t mk(input logic [7:0] cv, input logic co, input logic ov);
      exp_t e;
      e.c = cv; e.cout = co; e.ovf = ov;
      return e;
   endfunction

   // Integer reference model, 8-bit operands.
   function automatic exp_t model(input logic o, input logic [7:0] x, input logic [7:0] y,
                                  input logic ci, input bit sat);
      int sx, sy, ux, uy, cv, s;
      exp_t e;
      sx = int'($signed(x)); sy = int'($signed(y));
      ux = int'(x); uy = int'(y); cv = int'(ci);
      if (!o) begin
         s = sx + sy + cv;
         e.cout = ((ux + uy + cv) > 255);
      end else begin
         s = sx - sy - cv;
         e.cout = (ux < (uy + cv));
      end
      e.ovf = (s > 127) || (s < -128);
      if (sat && s > 127)       e.c = 8'h7F;
      else if (sat && s < -128) e.c = 8'h80;
      else                      e.c = s[7:0];
      return e;
   endfunction

   // Offer one beat to the selected instances; expectation is queued when
   // the beat is seen accepted.
   task automatic send(input logic ta, input logic tb, input logic [7:0] x, input logic [7:0] y,
                       input logic o, input logic ci, input exp_t ea, input exp_t eb);
      logic pa, pb, acc_a, acc_b;
      int guard;
      a = x; b = y; op = o; cin = ci;
      in_valid_a = ta; in_valid_b = tb;
      pa = ta; pb = tb; guard = 0;
      while ((pa || pb) && guard < 40) begin
         @(negedge clk);
         acc_a = pa && in_ready_a;
         acc_b = pb && in_ready_b;
         if (acc_a) q_a.push_back(ea);
         if (acc_b) q_b.push_back(eb);
         @(posedge clk); #1;
         if (acc_a) begin pa = 1'b0; in_valid_a = 1'b0; end
         if (acc_b) begin pb = 1'b0; in_valid_b = 1'b0; end
         guard++;
      end
      if (pa || pb) begin
         n_checks++;
         $display("FAIL send_timeout: beat not accepted within 40 cycles");
         in_valid_a = 1'b0; in_valid_b = 1'b0;
      end
   endtask

   // Scoreboard for the saturating instance.
   always @(negedge clk) begin
      if (!rst_n) begin
         q_a.delete();
         m_cnt_a = 0;
      end else begin
         dlv_a = 1'b0; e_a = '0;
         check("a_ovf_count", ovf_count_a, m_cnt_a);
         if (out_valid_a) begin
            if (q_a.size() == 0) begin
               n_checks++;
               $display("FAIL a_unexpected_beat: got c=%0h, expected no beat", c_a);
            end else begin
               e_a = q_a[0];
               check("a_c", c_a, e_a.c);
               check("a_carry_out", carry_out_a, e_a.cout);
               check("a_overflow", overflow_a, e_a.ovf);
               if (out_ready) begin
                  void'(q_a.pop_front());
                  dlv_a = 1'b1;
                  del_a++;
               end
            end
         end
         if (ovf_clr) m_cnt_a = 0;
         else if (dlv_a && e_a.ovf && m_cnt_a != 15) m_cnt_a++;
      end
   end

   // Scoreboard for the wrapping instance.
   always @(negedge clk) begin
      if (!rst_n) begin
         q_b.delete();
         m_cnt_b = 0;
      end else begin
         dlv_b = 1'b0; e_b = '0;
         check("b_ovf_count", ovf_count_b, m_cnt_b);
         if (out_valid_b) begin
            if (q_b.size() == 0) begin
               n_checks++;
               $display("FAIL b_unexpected_beat: got c=%0h, expected no beat", c_b);
            end else begin
               e_b = q_b[0];
               check("b_c", c_b, e_b.c);
               check("b_carry_out", carry_out_b, e_b.cout);
               check("b_overflow", overflow_b, e_b.ovf);
               if (out_ready) begin
                  void'(q_b.pop_front());
                  dlv_b = 1'b1;
                  del_b++;
               end
            end
         end
         if (ovf_clr) m_cnt_b = 0;
         else if (dlv_b && e_b.ovf && m_cnt_b != 65535) m_cnt_b++;
      end
   end

   initial begin
      int la, lb, bad, guard;
      logic [7:0] x, y;
      logic o, ci;

      //          op    a      b      cin   c_sat  c_wrap cout  ovf
      vt[0]  = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h7F, 8'h80, 1'b0, 1'b1};
      vt[1]  = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
      vt[2]  = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 8'hFE, 1'b1, 1'b0};
      vt[3]  = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
      vt[4]  = '{1'b1, 8'h10, 8'h10, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0};
      vt[5]  = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h80, 8'h00, 1'b1, 1'b1};
      vt[6]  = '{1'b0, 8'h7F, 8'h7F, 1'b1, 8'h7F, 8'hFF, 1'b0, 1'b1};
      vt[7]  = '{1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 8'h47, 1'b0, 1'b0};
      vt[8]  = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h7F, 8'h80, 1'b1, 1'b1};
      vt[9]  = '{1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0};
      vt[10] = '{1'b0, 8'hF0, 8'hF0, 1'b1, 8'hE1, 8'hE1, 1'b1, 1'b0};
      vt[11] = '{1'b1, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      vt[12] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0};
      vt[13] = '{1'b1, 8'h80, 8'h7F, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1};

      rst_n = 1'b0; a = '0; b = '0; op = 1'b0; cin = 1'b0;
      in_valid_a = 1'b0; in_valid_b = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready_a, 0);
      check("rst_out_valid", out_valid_a, 0);
      check("rst_c", c_a, 0);
      check("rst_carry_overflow", {carry_out_a, overflow_a}, 0);
      check("rst_ovf_count", ovf_count_a, 0);
      check("rst_b_out_valid", out_valid_b, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("release_in_ready", in_ready_a, 1);

      // Latency of a single beat, 0x7F + 0x01
      @(posedge clk); #1;
      send(1'b1, 1'b1, vt[0].a, vt[0].b, vt[0].op, vt[0].cin,
           mk(vt[0].c_sat, vt[0].cout, vt[0].ovf), mk(vt[0].c_wrap, vt[0].cout, vt[0].ovf));
      la = 0; lb = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (out_valid_a && la == 0) la = i;
         if (out_valid_b && lb == 0) lb = i;
      end
      check("latency_sat_3stage", la, 3);
      check("latency_wrap_2stage", lb, 2);
      check("first_ovf_count_a", ovf_count_a, 1);
      check("first_ovf_count_b", ovf_count_b, 1);
      @(posedge clk); #1;

      // Table vectors, back to back
      for (int i = 0; i < 14; i++) begin
         send(1'b1, 1'b1, vt[i].a, vt[i].b, vt[i].op, vt[i].cin,
              mk(vt[i].c_sat, vt[i].cout, vt[i].ovf), mk(vt[i].c_wrap, vt[i].cout, vt[i].ovf));
      end
      repeat (10) @(posedge clk);
      #1;

      // Stream of 10 beats with a 5-cycle downstream stall
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               x = 8'($urandom); y = 8'($urandom);
               o = 1'($urandom); ci = 1'($urandom);
               send(1'b1, 1'b0, x, y, o, ci, model(o, x, y, ci, 1'b1), '0);
            end
         end
         begin
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(negedge clk);
            check("stall_in_ready_low", in_ready_a, 0);
            check("stall_out_valid_held", out_valid_a, 1);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      repeat (10) @(posedge clk);
      #1;

      // Reset with two beats in flight
      send(1'b1, 1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, mk(8'h7F, 1'b0, 1'b1), mk(8'h80, 1'b0, 1'b1));
      send(1'b1, 1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, mk(8'h7F, 1'b0, 1'b1), mk(8'h80, 1'b0, 1'b1));
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid_a", out_valid_a, 0);
      check("midrst_out_valid_b", out_valid_b, 0);
      check("midrst_ovf_count_a", ovf_count_a, 0);
      check("midrst_ovf_count_b", ovf_count_b, 0);
      check("midrst_in_ready", in_ready_a, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid_a || out_valid_b) bad++;
      end
      check("no_stale_beat", bad, 0);
      @(posedge clk); #1;

      // Counter saturation at 15, then clear coinciding with an overflow beat
      for (int i = 0; i < 16; i++) begin
         send(1'b1, 1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, mk(8'h7F, 1'b0, 1'b1), '0);
      end
      repeat (6) @(posedge clk);
      #1;
      check("ovf_count_saturated", ovf_count_a, 15);
      out_ready = 1'b0;
      send(1'b1, 1'b0, 8'h80, 8'h01, 1'b1, 1'b0, mk(8'h80, 1'b0, 1'b1), '0);
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!out_valid_a && guard < 10);
      if (!out_valid_a) begin
         n_checks++;
         $display("FAIL clr_wait_timeout: out_valid never rose");
      end
      @(posedge clk); #1;
      out_ready = 1'b1; ovf_clr = 1'b1;
      @(posedge clk); #1;
      ovf_clr = 1'b0;
      check("clr_wins_over_increment", ovf_count_a, 0);

      repeat (10) @(posedge clk);
      #1;
      check("a_queue_drained", q_a.size(), 0);
      check("b_queue_drained", q_b.size(), 0);
      check("a_delivered_total", del_a, 42);
      check("b_delivered_total", del_b, 15);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fixed_point_addsub_pipe.md
FIXED_POINT_ADDSUB_PIPE -- requirements
Module: fixed_point_addsub_pipe

Interface
REQ-001 Parameter N, default 32: data path width in bits, two's complement, legal range 2..64.
REQ-002 Parameter STAGES, default 2: pipeline register stages, legal range 1..4.
REQ-003 Parameter SATURATE, default 1: 1 = clamp on signed overflow, 0 = wrap.
REQ-004 Parameter CNT_W, default 16: overflow counter width.
REQ-005 clk  input  1  single clock; all state rising-edge triggered.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  input  1  operand beat present.
REQ-008 in_ready  output  1  block accepts operand beat this cycle.
REQ-009 a  input  N  minuend/augend, signed.
REQ-010 b  input  N  subtrahend/addend, signed.
REQ-011 op  input  1  0 = add, 1 = subtract.
REQ-012 carry_in  input  1  add: carry-in; subtract: borrow-in.
REQ-013 out_valid  output  1  result beat present.
REQ-014 out_ready  input  1  downstream accepts result beat.
REQ-015 c  output  N  result, signed.
REQ-016 carry_out  output  1  add: unsigned carry; subtract: unsigned borrow.
REQ-017 overflow  output  1  signed overflow occurred for this beat.
REQ-018 ovf_count  output  CNT_W  count of accepted result beats with overflow=1.
REQ-019 ovf_clr  input  1  synchronous clear of ovf_count.

Function
REQ-020 Beat accepted when in_valid && in_ready; beat delivered when out_valid && out_ready.
REQ-021 Arithmetic on N+1-bit sign-extended operands: add r = a + b + carry_in; subtract r = a + ~b + !carry_in, i.e. a - b - carry_in.
REQ-022 overflow = 1 when r[N] != r[N-1].
REQ-023 carry_out: add = unsigned carry out of bit N-1; subtract = 1 when unsigned a < unsigned b + carry_in, else 0.
REQ-024 SATURATE=1 with overflow: c = 2^(N-1)-1 if r[N]=0, c = -2^(N-1) if r[N]=1; otherwise c = r[N-1:0].
REQ-025 SATURATE=0: c = r[N-1:0] always; overflow still reported.
REQ-026 Elastic pipeline of STAGES registers, each holding valid, c, carry_out, overflow; arithmetic completes before stage 1.
REQ-027 Stage k loads when empty, or when its content moves to stage k+1 or out in the same cycle; last stage moves out on out_ready.
REQ-028 in_ready = !stage1_valid || stage1 advancing; combinational from out_ready through the stall chain, no combinational in_valid->out_valid path.
REQ-029 Latency STAGES cycles from acceptance to out_valid without backpressure; throughput one beat per cycle sustained.
REQ-030 While out_valid && !out_ready: c, carry_out and overflow held stable, no beat dropped or duplicated.
REQ-031 Beats delivered in acceptance order; an empty pipeline holds at most STAGES beats.
REQ-032 ovf_count increments by 1 on each delivered beat with overflow=1; saturates at 2^CNT_W-1, no wrap.
REQ-033 ovf_clr in same cycle as an increment: result 0, clear wins.
REQ-034 Input operands sampled only on acceptance; a, b, op, carry_in ignored otherwise.

Reset
REQ-035 rst_n low: all stage valids 0, out_valid 0, c 0, carry_out 0, overflow 0, ovf_count 0, asynchronously.
REQ-036 in_ready = 0 while rst_n low; first acceptance possible on the first rising clk edge after rst_n deasserts.
REQ-037 Reset mid-operation discards all in-flight beats; none delivered after reset release.

Verification
REQ-038 N=8, SAT=1, STAGES=2, out_ready=1: add 0x7F+0x01, cin=0 -> after 2 cycles c=0x7F, overflow=1, carry_out=0, ovf_count=1.
REQ-039 N=8, SAT=0: add 0x7F+0x01 -> c=0x80, overflow=1; add 0xFF+0x01 -> c=0x00, carry_out=1, overflow=0.
REQ-040 N=8, SAT=1: sub 0x05-0x07 -> c=0xFE, carry_out=1, overflow=0; sub 0x80-0x01 -> c=0x80, overflow=1, carry_out=0; sub 0x10-0x10, cin=1 -> c=0xFF, carry_out=1.
REQ-041 STAGES=3: stream 10 beats, hold out_ready=0 for 5 cycles mid-stream -> in_ready falls after 3 beats buffered, c held stable, all 10 delivered in order, none lost.
REQ-042 Assert rst_n=0 with 2 beats in flight -> out_valid=0 immediately, ovf_count=0, no stale beat after release.
REQ-043 Drive ovf_count to 2^CNT_W-1 (CNT_W=4: 15) then one more overflow beat -> stays 15; ovf_clr with coincident overflow beat -> 0.
